encoder_32_to_5_stream: RTL and testbench

- Sequential 32-to-5 encoder: the inverse of the 5-to-32 decoder.
- Captures one-hot or multi-hot request pulses into a 32-bit sticky pending set.
- Streams out the 5-bit index of each pending bit, one per valid/ready transfer.
- Used to turn per-line event/interrupt strobes back into binary indices for the control path.

---
 rtl/encoder_32_to_5_stream.sv | 65 ++++++
 tb/tb_encoder_32_to_5_stream.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_32_to_5_stream.sv
// encoder_32_to_5_stream: captures request strobes into a sticky pending set and
// streams out each pending index over a valid/ready handshake.
module encoder_32_to_5_stream #(
  parameter int ROUND_ROBIN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] req,
  input  logic        ready,
  output logic        valid,
  output logic [4:0]  out,
  output logic [31:0] pending,
  output logic [5:0]  pending_count
);
  typedef enum logic {IDLE, OFFER} state_e;
  state_e      state_q, state_d;
  logic [31:0] pending_q, pending_d, clear_mask;
  logic [4:0]  out_q, out_d, last_q, last_d, start, sel, idx;
  logic [5:0]  count_q, count_d;
  logic        accept, hold, load;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      out_q     <= '0;
      last_q    <= 5'd31;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      out_q     <= out_d;
      last_q    <= last_d;
      count_q   <= count_d;
    end
  end
  // set wins over clear because capture is OR-ed in after the clear
  always_comb begin
    accept     = state_q == OFFER && ready;
    clear_mask = accept ? 32'd1 << out_q : '0;
    pending_d  = (pending_q & ~clear_mask) | (ena ? req : '0);
    last_d     = accept ? out_q : last_q;
    start      = ROUND_ROBIN != 0 ? last_d + 5'd1 : 5'd0;
    sel        = '0;
    idx        = '0;
    count_d    = '0;
    for (int i = 31; i >= 0; i--) begin
      idx = start + 5'(i);
      if (pending_d[idx]) sel = idx;
    end
    for (int i = 0; i < 32; i++) count_d += 6'(pending_d[i]);
  end
  always_comb begin
    hold    = state_q == OFFER && !ready;
    load    = |pending_d && !hold;
    state_d = hold || |pending_d ? OFFER : IDLE;
    out_d   = load ? sel : out_q;
  end
  always_comb begin
    valid         = state_q == OFFER;
    out           = out_q;
    pending       = pending_q;
    pending_count = count_q;
  end
endmodule

// File: tb/tb_encoder_32_to_5_stream.sv
// tb_encoder_32_to_5_stream: directed scoreboard bench for fixed and round-robin encoders.
module tb_encoder_32_to_5_stream;
  logic clk = 1'b0;
  logic rst;
  logic f_ena, f_ready, f_valid, r_ena, r_ready, r_valid;
  logic [31:0] f_req, f_pend, r_req, r_pend;
  logic [4:0] f_out, r_out;
  logic [5:0] f_cnt, r_cnt;
  int tests = 0;
  int fails = 0;
  int fq[$];
  int rq[$];

  always #5 clk = ~clk;

  encoder_32_to_5_stream #(.ROUND_ROBIN(0)) u_fix (
    .clk(clk), .rst(rst), .ena(f_ena), .req(f_req), .ready(f_ready),
    .valid(f_valid), .out(f_out), .pending(f_pend), .pending_count(f_cnt));

  encoder_32_to_5_stream #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst(rst), .ena(r_ena), .req(r_req), .ready(r_ready),
    .valid(r_valid), .out(r_out), .pending(r_pend), .pending_count(r_cnt));

  always @(negedge clk) begin
    if (rst && f_valid && f_ready) begin
      tests++;
      if (fq.size() == 0) begin
        fails++;
        $display("FAIL fix_unexpected: out=%0d offered with no expected index", f_out);
      end else begin
        int e;
        e = fq.pop_front();
        if (int'(f_out) != e) begin
          fails++;
          $display("FAIL fix_out: got %0d expected %0d", f_out, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && r_valid && r_ready) begin
      tests++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL rr_unexpected: out=%0d offered with no expected index", r_out);
      end else begin
        int e;
        e = rq.pop_front();
        if (int'(r_out) != e) begin
          fails++;
          $display("FAIL rr_out: got %0d expected %0d", r_out, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    f_ena = 1'b1; f_req = '0; f_ready = 1'b0;
    r_ena = 1'b1; r_req = '0; r_ready = 1'b0;
    #3;
    chk("rst_valid", 32'(f_valid), 0);
    chk("rst_out", 32'(f_out), 0);
    chk("rst_pend", f_pend, 0);
    chk("rst_cnt", 32'(f_cnt), 0);
    tick();
    rst = 1'b1;
    tick();
    // single request, immediately accepted
    f_ready = 1'b1; f_req = 32'h1; fq.push_back(0);
    tick();
    f_req = '0;
    chk("single_valid", 32'(f_valid), 1);
    chk("single_out", 32'(f_out), 0);
    tick();
    chk("single_valid_after", 32'(f_valid), 0);
    chk("single_pend_after", f_pend, 0);
    chk("single_cnt_after", 32'(f_cnt), 0);
    // fixed priority back-to-back stream
    f_req = 32'h8000_0011; fq.push_back(0); fq.push_back(4); fq.push_back(31);
    tick();
    f_req = '0;
    chk("seq_cnt3", 32'(f_cnt), 3);
    tick();
    chk("seq_cnt2", 32'(f_cnt), 2);
    chk("seq_valid2", 32'(f_valid), 1);
    chk("seq_out4", 32'(f_out), 4);
    tick();
    chk("seq_cnt1", 32'(f_cnt), 1);
    chk("seq_out31", 32'(f_out), 31);
    tick();
    chk("seq_cnt0", 32'(f_cnt), 0);
    chk("seq_valid0", 32'(f_valid), 0);
    // offer stays frozen under backpressure
    f_req = 32'h11; fq.push_back(0);
    tick();
    f_req = '0;
    tick();
    f_ready = 1'b0;
    chk("hold_out4", 32'(f_out), 4);
    tick();
    tick();
    f_req = 32'h2;
    tick();
    f_req = '0;
    chk("hold_out_frozen", 32'(f_out), 4);
    chk("hold_pend", f_pend, 32'h12);
    chk("hold_cnt", 32'(f_cnt), 2);
    tick();
    chk("hold_out_still", 32'(f_out), 4);
    fq.push_back(4); fq.push_back(1);
    f_ready = 1'b1;
    tick();
    chk("hold_next_out1", 32'(f_out), 1);
    tick();
    chk("hold_done", 32'(f_valid), 0);
    // same-bit clear and set collision
    f_ready = 1'b0; f_req = 32'h8;
    tick();
    chk("coll_out3", 32'(f_out), 3);
    chk("coll_cnt_before", 32'(f_cnt), 1);
    f_ready = 1'b1; fq.push_back(3);
    tick();
    f_req = '0;
    chk("coll_cnt_after", 32'(f_cnt), 1);
    chk("coll_pend", f_pend, 32'h8);
    chk("coll_valid", 32'(f_valid), 1);
    fq.push_back(3);
    tick();
    chk("coll_done", 32'(f_valid), 0);
    chk("coll_cnt0", 32'(f_cnt), 0);
    // capture disabled
    f_ena = 1'b0; f_req = 32'hF0;
    tick();
    tick();
    chk("ena_pend", f_pend, 0);
    chk("ena_valid", 32'(f_valid), 0);
    f_ena = 1'b1; f_req = '0;
    // asynchronous reset mid-offer
    f_ready = 1'b0; f_req = 32'h30;
    tick();
    f_req = '0;
    chk("arst_pre_valid", 32'(f_valid), 1);
    chk("arst_pre_out", 32'(f_out), 4);
    chk("arst_pre_cnt", 32'(f_cnt), 2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(f_valid), 0);
    chk("arst_out", 32'(f_out), 0);
    chk("arst_pend", f_pend, 0);
    chk("arst_cnt", 32'(f_cnt), 0);
    tick();
    rst = 1'b1;
    tick();
    // round-robin sweep of all 32 lines
    r_ready = 1'b1; r_req = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) rq.push_back(i);
    tick();
    r_req = '0;
    chk("rr_cnt32", 32'(r_cnt), 32);
    chk("rr_first", 32'(r_out), 0);
    for (int i = 0; i < 32; i++) tick();
    chk("rr_sweep_done", 32'(r_valid), 0);
    chk("rr_sweep_cnt", 32'(r_cnt), 0);
    // restart after last_grant=31
    r_req = 32'h21; rq.push_back(0); rq.push_back(5);
    tick();
    r_req = '0;
    chk("rr_wrap31_out", 32'(r_out), 0);
    tick();
    chk("rr_next5", 32'(r_out), 5);
    tick();
    chk("rr_idle1", 32'(r_valid), 0);
    // wrap from last_grant=5
    r_req = 32'h84; rq.push_back(7); rq.push_back(2);
    tick();
    r_req = '0;
    chk("rr_wrap5_out", 32'(r_out), 7);
    tick();
    chk("rr_wrap_to2", 32'(r_out), 2);
    tick();
    chk("rr_idle2", 32'(r_valid), 0);
    chk("fix_queue_empty", 32'(fq.size()), 0);
    chk("rr_queue_empty", 32'(rq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
